// File: rtl/disp_pkg.sv
// Shared defaults, digit-position width helper and scan FSM states for display_scan.
package disp_pkg;
  localparam int DEF_NUM_DIGITS = 6;
  localparam int DEF_DIGIT_W    = 5;
  localparam int DEF_DWELL      = 2;
  localparam int DEF_BLANK      = 0;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

  // A single position still needs a one-bit index.
  function automatic int pos_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/display_scan_timer.sv
// Scan sequencer for display_scan: dwell/blank counting, START/SHOW/BLANK FSM and
// digit index wrap; announces SHOW entries (step) and frame starts one edge ahead.
module display_scan_timer
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int DWELL      = DEF_DWELL,
  parameter int BLANK      = DEF_BLANK,
  localparam int POS_W     = pos_width(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             step,
  output logic [POS_W-1:0] step_idx,
  output logic             frame_go,
  output logic [1:0]       next_state
);
  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  scan_state_e      state, state_d;
  logic [POS_W-1:0] idx, idx_d, idx_inc;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             dwell_done, blank_done;

  // Explicit wrap keeps non-power-of-2 digit counts inside the valid range.
  assign idx_inc    = (idx == POS_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
  assign dwell_done = (cnt == CNT_W'(DWELL - 1));
  assign blank_done = (cnt == CNT_W'(BLANK - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_START;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt + 1'b1;
    step    = 1'b0;
    case (state)
      ST_START: begin
        state_d = ST_SHOW;
        idx_d   = '0;
        cnt_d   = '0;
        step    = 1'b1;
      end
      ST_SHOW: begin
        if (dwell_done) begin
          cnt_d = '0;
          if (BLANK > 0) begin
            state_d = ST_BLANK;
          end else begin
            idx_d = idx_inc;
            step  = 1'b1;
          end
        end
      end
      ST_BLANK: begin
        if (blank_done) begin
          state_d = ST_SHOW;
          idx_d   = idx_inc;
          cnt_d   = '0;
          step    = 1'b1;
        end
      end
      default: begin
        state_d = ST_START;
        cnt_d   = '0;
      end
    endcase
  end

  assign step_idx   = idx_d;
  assign frame_go   = step && (idx_d == '0);
  assign next_state = state_d;
endmodule

// File: rtl/display_scan.sv
// Multiplexed-digit display driver: shadow shift register, tear-free commit to the
// active register at frame start, registered scan outputs. Option: DISPLAY_SCAN_LZB_EN.
module display_scan
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int DIGIT_W    = DEF_DIGIT_W,
  parameter int DWELL      = DEF_DWELL,
  parameter int BLANK      = DEF_BLANK,
  localparam int POS_W     = pos_width(NUM_DIGITS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] in_digit,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               commit,
  output logic [POS_W-1:0]   digit_pos,
  output logic [DIGIT_W-1:0] digit_cur,
  output logic               digit_en,
  output logic               frame_start
);
  logic [DIGIT_W-1:0] shadow [NUM_DIGITS];
  logic [DIGIT_W-1:0] active [NUM_DIGITS];
  logic               pending, pending_d, publish, shift_go, show_en;
  logic               step, frame_go;
  logic [POS_W-1:0]   step_idx;
  logic [1:0]         next_state;

  display_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .DWELL      (DWELL),
    .BLANK      (BLANK)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (step),
    .step_idx   (step_idx),
    .frame_go   (frame_go),
    .next_state (next_state)
  );

  // Handshake: a digit transfers on any edge where in_valid && in_ready; in_valid
  // may be held without transfer while in_ready is low, and in_ready does not
  // depend on in_valid. in_ready stays low from commit until the publish edge.
  assign shift_go  = in_valid && in_ready;
  assign publish   = frame_go && pending;
  assign pending_d = publish ? 1'b0 : (pending || commit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= '0;
    end else if (shift_go) begin
      shadow[0] <= in_digit;
      for (int i = 1; i < NUM_DIGITS; i++) shadow[i] <= shadow[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) active[i] <= '0;
    end else if (publish) begin
      for (int i = 0; i < NUM_DIGITS; i++) active[i] <= shadow[i];
    end
  end

`ifdef DISPLAY_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] lzb_mask, lzb_mask_d;
  logic                  lzb_seen;

  // Mask zeros from the top position down until the first nonzero; position 0 always shows.
  always_comb begin
    lzb_mask_d = '0;
    lzb_seen   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lzb_seen      = lzb_seen | (shadow[i] != '0);
      lzb_mask_d[i] = ~lzb_seen;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lzb_mask <= '0;
    else if (publish) lzb_mask <= lzb_mask_d;
  end

  assign show_en = ~lzb_mask[step_idx];
`else
  assign show_en = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending     <= 1'b0;
      in_ready    <= 1'b0;
      digit_pos   <= '0;
      digit_cur   <= '0;
      digit_en    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pending     <= pending_d;
      in_ready    <= ~pending_d;
      frame_start <= frame_go;
      if (step) begin
        digit_pos <= step_idx;
        // On the publish edge active is still old; the new first digit comes from shadow.
        digit_cur <= publish ? shadow[0] : active[step_idx];
        digit_en  <= show_en;
      end else if (next_state == ST_BLANK) begin
        digit_en  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: 6-digit no-blank instance and 5-digit blanking instance.
`timescale 1ns/1ps
module tb_display_scan;
  localparam int DW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DW-1:0] a_in_digit, b_in_digit;
  logic          a_in_valid, a_in_ready, a_commit, a_en, a_frame;
  logic          b_in_valid, b_in_ready, b_commit, b_en, b_frame;
  logic [2:0]    a_pos, b_pos;
  logic [DW-1:0] a_cur, b_cur;

  display_scan #(.NUM_DIGITS(6), .DIGIT_W(DW), .DWELL(2), .BLANK(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_digit(a_in_digit), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .commit(a_commit), .digit_pos(a_pos), .digit_cur(a_cur),
    .digit_en(a_en), .frame_start(a_frame)
  );

  display_scan #(.NUM_DIGITS(5), .DIGIT_W(DW), .DWELL(2), .BLANK(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_digit(b_in_digit), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .commit(b_commit), .digit_pos(b_pos), .digit_cur(b_cur),
    .digit_en(b_en), .frame_start(b_frame)
  );

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];   // {digit_en, digit_cur} per displayed slot

  // ---------------- driver tasks ----------------
  task automatic push_frame(input logic [6*DW-1:0] codes, input logic [5:0] ens);
    for (int s = 0; s < 6; s++) exp_q.push_back({ens[s], codes[s*DW +: DW]});
  endtask

  task automatic shift_a(input logic [DW-1:0] d);
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL shift_a ready: in_ready=%b, need 1", a_in_ready);
    end
    a_in_valid = 1'b1;
    a_in_digit = d;
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic shift_b(input logic [DW-1:0] d);
    checks++;
    if (b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL shift_b ready: in_ready=%b, need 1", b_in_ready);
    end
    b_in_valid = 1'b1;
    b_in_digit = d;
    @(negedge clk);
    b_in_valid = 1'b0;
  endtask

  task automatic commit_a();
    a_commit = 1'b1;
    @(negedge clk);
    a_commit = 1'b0;
  endtask

  task automatic wait_frame(input bit sel_b, input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = sel_b ? b_frame : a_frame;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: frame_start not seen in 40 cycles (got 0, need 1)", tag);
    end
  endtask

  // Starts on the first cycle of a frame on dut_a; returns on the first cycle of the next.
  task automatic check_frame_a(input string tag, input bit do_shift, input logic [DW-1:0] sd);
    logic [DW:0] e;
    for (int s = 0; s < 6; s++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s pos%0d: scoreboard empty", tag, s);
      end else begin
        e = exp_q.pop_front();
        if (a_pos !== 3'(s) || a_cur !== e[DW-1:0] || a_en !== e[DW] || a_frame !== (s == 0)) begin
          errors++;
          $display("FAIL %s pos%0d: got pos=%0d cur=%0d en=%b fs=%b, need pos=%0d cur=%0d en=%b fs=%b",
                   tag, s, a_pos, a_cur, a_en, a_frame, s, e[DW-1:0], e[DW], (s == 0));
        end
      end
      if (s == 0 && do_shift) begin
        a_in_valid = 1'b1;
        a_in_digit = sd;
      end
      @(negedge clk);
      a_in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (a_pos !== 3'd0 || a_cur !== 5'd0 || a_en !== 1'b0 || a_frame !== 1'b0 || a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s a: got pos=%0d cur=%0d en=%b fs=%b rdy=%b, need all 0",
               tag, a_pos, a_cur, a_en, a_frame, a_in_ready);
    end
    checks++;
    if (b_pos !== 3'd0 || b_cur !== 5'd0 || b_en !== 1'b0 || b_frame !== 1'b0 || b_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s b: got pos=%0d cur=%0d en=%b fs=%b rdy=%b, need all 0",
               tag, b_pos, b_cur, b_en, b_frame, b_in_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_digit = '0; a_commit = 1'b0;
    b_in_valid = 1'b0; b_in_digit = '0; b_commit = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b, need 1", a_in_ready);
    end
    push_frame('0, 6'b111111);
    check_frame_a("reset_frame", 1'b0, '0);
  endtask

  task automatic test_commit();
    bit early = 1'b0;
    bit seen  = 1'b0;
    for (int d = 1; d <= 6; d++) shift_a(DW'(d));
    commit_a();
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL commit_ready_low: in_ready=%b, need 0", a_in_ready);
    end
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = a_frame;
      if (!seen && a_in_ready !== 1'b0) early = 1'b1;
    end
    checks++;
    if (!seen || early || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL commit_publish: frame_seen=%b ready_early=%b ready_at_frame=%b, need 1 0 1",
               seen, early, a_in_ready);
    end
    push_frame({5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6}, 6'b111111);
    check_frame_a("commit_frame1", 1'b0, '0);
    push_frame({5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6}, 6'b111111);
    check_frame_a("commit_frame2", 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    for (int d = 7; d <= 11; d++) shift_a(DW'(d));
    a_in_valid = 1'b1; a_in_digit = 5'd12; a_commit = 1'b1;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_low: in_ready=%b, need 0", a_in_ready);
    end
    a_in_valid = 1'b1; a_in_digit = 5'd13; a_commit = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0; a_commit = 1'b0;
    wait_frame(1'b0, "b2b_wait");
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_high: in_ready=%b, need 1", a_in_ready);
    end
    push_frame({5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12}, 6'b111111);
    check_frame_a("b2b_frame1", 1'b1, 5'd20);
    push_frame({5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12}, 6'b111111);
    check_frame_a("b2b_single_publish", 1'b0, '0);
  endtask

  task automatic test_blank();
    logic [DW:0] e;
    int s;
    for (int d = 1; d <= 5; d++) shift_b(DW'(d));
    b_commit = 1'b1;
    @(negedge clk);
    b_commit = 1'b0;
    wait_frame(1'b1, "blank_wait");
    for (int k = 0; k < 15; k++) exp_q.push_back({((k % 3) < 2), DW'(5 - k / 3)});
    for (int k = 0; k < 15; k++) begin
      s = k / 3;
      e = exp_q.pop_front();
      checks++;
      if (b_pos !== 3'(s) || b_cur !== e[DW-1:0] || b_en !== e[DW] || b_frame !== (k == 0)) begin
        errors++;
        $display("FAIL blank c%0d: got pos=%0d cur=%0d en=%b fs=%b, need pos=%0d cur=%0d en=%b fs=%b",
                 k, b_pos, b_cur, b_en, b_frame, s, e[DW-1:0], e[DW], (k == 0));
      end
      @(negedge clk);
    end
    checks++;
    if (b_frame !== 1'b1 || b_pos !== 3'd0 || b_cur !== 5'd5 || b_en !== 1'b1) begin
      errors++;
      $display("FAIL blank_period: got fs=%b pos=%0d cur=%0d en=%b, need 1 0 5 1",
               b_frame, b_pos, b_cur, b_en);
    end
  endtask

`ifdef DISPLAY_SCAN_LZB_EN
  task automatic test_lzb();
    shift_a(5'd0); shift_a(5'd0); shift_a(5'd0); shift_a(5'd4); shift_a(5'd0); shift_a(5'd7);
    commit_a();
    wait_frame(1'b0, "lzb_wait1");
    push_frame({5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd7}, 6'b000111);
    check_frame_a("lzb_mixed", 1'b0, '0);
    for (int i = 0; i < 6; i++) shift_a(5'd0);
    commit_a();
    wait_frame(1'b0, "lzb_wait2");
    push_frame('0, 6'b000001);
    check_frame_a("lzb_all_zero", 1'b0, '0);
  endtask
`endif

  task automatic test_reset_mid();
    shift_a(5'd9); shift_a(5'd9); shift_a(5'd9);
    commit_a();
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_pending: in_ready=%b, need 0", a_in_ready);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_pending_cleared: in_ready=%b, need 1", a_in_ready);
    end
    push_frame('0, 6'b111111);
    check_frame_a("mid_restart", 1'b0, '0);
    commit_a();
    wait_frame(1'b0, "mid_wait");
    push_frame('0, 6'b111111);
    check_frame_a("mid_shadow_lost", 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_commit();
    test_back_to_back();
    test_blank();
`ifdef DISPLAY_SCAN_LZB_EN
    test_lzb();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end
endmodule
